// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe playfield: FSM states, LFSR taps and the
// default screen geometry also used by the vga and bird blocks.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int DEF_X_W          = 11;
    localparam int DEF_SCREEN_W     = 640;
    localparam int DEF_PIPE_SPACING = 340;
    localparam int DEF_PIPE_W       = 60;
    localparam int DEF_BIRD_X       = 160;

    function automatic logic [15:0] rotl16(input logic [15:0] s, input logic [3:0] r);
        return (s << r) | (s >> (5'd16 - {1'b0, r}));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts left every clock, loads SEED on reset.
module lfsr16
    import pipe_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        segclk,
    input  logic        reset,
    output logic [15:0] lfsr
);

    logic feedback;

    assign feedback = ^(lfsr & LFSR_TAPS);

    always_ff @(posedge segclk or posedge reset) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe field: moves N_PIPES obstacles left, respawns them with a
// random gap height, and counts bird passes. Macro PIPE_FIELD_SPEEDUP_EN
// enables the score-driven speed increase.
module pipe_field
    import pipe_pkg::*;
#(
    parameter int          N_PIPES        = 2,
    parameter int          X_W            = DEF_X_W,
    parameter int          SCREEN_W       = DEF_SCREEN_W,
    parameter int          PIPE_SPACING   = DEF_PIPE_SPACING,
    parameter int          PIPE_W         = DEF_PIPE_W,
    parameter int          BIRD_X         = DEF_BIRD_X,
    parameter int          Y_MIN          = 80,
    parameter int          Y_RANGE_LOG2   = 8,
    parameter int          SPEED          = 2,
    parameter int          MAX_SPEED      = 6,
    parameter int          SPEEDUP_PASSES = 8,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic                   gameClk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   finished,
    output logic [N_PIPES*X_W-1:0] pipe_x,
    output logic [N_PIPES*X_W-1:0] pipe_y,
    output logic                   pass_column,
    output logic [7:0]             score,
    output logic [3:0]             cur_speed,
    output logic                   running,
    output state_t                 dbg_state
);

    localparam logic [X_W:0]   WRAP_E    = (X_W+1)'(N_PIPES * PIPE_SPACING);
    localparam logic [X_W:0]   PIPE_W_E  = (X_W+1)'(PIPE_W);
    localparam logic [X_W:0]   BIRD_X_E  = (X_W+1)'(BIRD_X);
    localparam logic [X_W-1:0] Y_MIN_X   = X_W'(Y_MIN);
    localparam logic [X_W-1:0] Y_START   = X_W'(Y_MIN + (1 << (Y_RANGE_LOG2 - 1)));
    localparam logic [15:0]    Y_MASK    = 16'((1 << Y_RANGE_LOG2) - 1);
    localparam logic [3:0]     SPEED_L   = 4'(SPEED);
    localparam logic [3:0]     SPEED_CAP = 4'(MAX_SPEED);
    localparam logic [7:0]     PASS_STEP = 8'(SPEEDUP_PASSES);
`ifdef PIPE_FIELD_SPEEDUP_EN
    localparam bit             SPEEDUP_ON = 1'b1;
`else
    localparam bit             SPEEDUP_ON = 1'b0;
`endif

    state_t           state;
    state_t           state_next;
    logic [15:0]      lfsr;
    logic [X_W-1:0]   px_q   [N_PIPES];
    logic [X_W-1:0]   py_q   [N_PIPES];
    logic [X_W:0]     old_ext[N_PIPES];
    logic [X_W:0]     nx_ext [N_PIPES];
    logic [X_W-1:0]   ny     [N_PIPES];
    logic [15:0]      rot    [N_PIPES];
    logic [X_W:0]     spd_ext;
    logic             pass_any;
    logic             enter_run;
    logic             advance;
    logic [7:0]       score_inc;
    logic             score_sat;
    logic             speed_bump;

    function automatic logic [X_W-1:0] home_x(input int i);
        return X_W'(SCREEN_W + i * PIPE_SPACING);
    endfunction

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .segclk (gameClk),
        .reset  (reset),
        .lfsr   (lfsr)
    );

    always_ff @(posedge gameClk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // finished is only examined in RUN, so it naturally wins over start there.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)    state_next = ST_RUN;
            ST_RUN:  if (finished) state_next = ST_HALT;
            ST_HALT: if (start)    state_next = ST_RUN;
            default:               state_next = ST_IDLE;
        endcase
    end

    assign enter_run = (state != ST_RUN) && (state_next == ST_RUN);
    assign advance   = (state == ST_RUN) && (state_next == ST_RUN);

    // Arithmetic is one bit wider than the coordinates so right edges and
    // the wrap sum never overflow.
    always_comb begin
        spd_ext  = (X_W+1)'(cur_speed);
        pass_any = 1'b0;
        for (int i = 0; i < N_PIPES; i++) begin
            old_ext[i] = {1'b0, px_q[i]};
            rot[i]     = rotl16(lfsr, 4'((3 * i) % 16));
            if (old_ext[i] > spd_ext) begin
                nx_ext[i] = old_ext[i] - spd_ext;
                ny[i]     = py_q[i];
            end else begin
                nx_ext[i] = old_ext[i] + WRAP_E - spd_ext;
                ny[i]     = Y_MIN_X + X_W'(rot[i] & Y_MASK);
            end
            if ((old_ext[i] + PIPE_W_E > BIRD_X_E) && (nx_ext[i] + PIPE_W_E <= BIRD_X_E)) begin
                pass_any = 1'b1;
            end
        end
    end

    assign score_inc  = score + 8'd1;
    assign score_sat  = (score == 8'hFF);
    assign speed_bump = SPEEDUP_ON && pass_any && !score_sat &&
                        ((score_inc % PASS_STEP) == 8'd0) && (cur_speed < SPEED_CAP);

    always_ff @(posedge gameClk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_PIPES; i++) begin
                px_q[i] <= home_x(i);
                py_q[i] <= Y_START;
            end
            score       <= 8'd0;
            cur_speed   <= SPEED_L;
            pass_column <= 1'b0;
        end else if (enter_run) begin
            for (int i = 0; i < N_PIPES; i++) begin
                px_q[i] <= home_x(i);
                py_q[i] <= Y_START;
            end
            score       <= 8'd0;
            cur_speed   <= SPEED_L;
            pass_column <= 1'b0;
        end else if (advance) begin
            for (int i = 0; i < N_PIPES; i++) begin
                px_q[i] <= nx_ext[i][X_W-1:0];
                py_q[i] <= ny[i];
            end
            pass_column <= pass_any;
            if (pass_any && !score_sat) begin
                score <= score_inc;
            end
            if (speed_bump) begin
                cur_speed <= cur_speed + 4'd1;
            end
        end else begin
            pass_column <= 1'b0;
        end
    end

    for (genvar g = 0; g < N_PIPES; g++) begin : g_pack
        assign pipe_x[g*X_W +: X_W] = px_q[g];
        assign pipe_y[g*X_W +: X_W] = py_q[g];
    end

    assign running   = (state == ST_RUN);
    assign dbg_state = state;

endmodule

// File: tb/tb_pipe_field.sv
// Directed-plus-random bench for pipe_field, checked every tick against a
// behavioural model of the playfield rules.
module tb_pipe_field;
    import pipe_pkg::*;

    localparam int NP = 2;
    localparam int XW = 11;
`ifdef PIPE_FIELD_SPEEDUP_EN
    localparam bit M_SPEEDUP = 1'b1;
`else
    localparam bit M_SPEEDUP = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic             gameClk = 1'b0;
    logic             reset;
    logic             start;
    logic             finished;
    logic [NP*XW-1:0] pipe_x;
    logic [NP*XW-1:0] pipe_y;
    logic             pass_column;
    logic [7:0]       score;
    logic [3:0]       cur_speed;
    logic             running;
    state_t           dbg_state;

    int total = 0;
    int bad   = 0;

    int m_x[NP];
    int m_y[NP];
    int m_score;
    int m_speed;
    int m_pass;
    int m_lfsr;
    int m_state;

    pipe_field dut (
        .gameClk     (gameClk),
        .reset       (reset),
        .start       (start),
        .finished    (finished),
        .pipe_x      (pipe_x),
        .pipe_y      (pipe_y),
        .pass_column (pass_column),
        .score       (score),
        .cur_speed   (cur_speed),
        .running     (running),
        .dbg_state   (dbg_state)
    );

    always #5 gameClk = ~gameClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int px(input int i);
        return int'(pipe_x[i*XW +: XW]);
    endfunction

    function automatic int py(input int i);
        return int'(pipe_y[i*XW +: XW]);
    endfunction

    task automatic model_home();
        for (int i = 0; i < NP; i++) begin
            m_x[i] = 640 + 340 * i;
            m_y[i] = 80 + 128;
        end
        m_score = 0;
        m_speed = 2;
        m_pass  = 0;
    endtask

    task automatic model_reset();
        model_home();
        m_state = M_IDLE;
        m_lfsr  = 16'hACE1;
    endtask

    // One rising edge of the game clock with the given inputs.
    task automatic model_edge(input bit s, input bit f);
        int old_x, new_x, rot, r, hits;
        m_pass = 0;
        if ((m_state == M_IDLE || m_state == M_HALT) && s) begin
            model_home();
            m_state = M_RUN;
        end else if (m_state == M_RUN && f) begin
            m_state = M_HALT;
        end else if (m_state == M_RUN) begin
            hits = 0;
            for (int i = 0; i < NP; i++) begin
                old_x = m_x[i];
                if (old_x > m_speed) begin
                    new_x = old_x - m_speed;
                end else begin
                    new_x = old_x - m_speed + NP * 340;
                    r = (3 * i) % 16;
                    rot = ((m_lfsr << r) | (m_lfsr >> (16 - r))) & 16'hFFFF;
                    m_y[i] = 80 + (rot % 256);
                end
                if (old_x + 60 > 160 && new_x + 60 <= 160) hits++;
                m_x[i] = new_x;
            end
            if (hits > 0) begin
                m_pass = 1;
                if (m_score < 255) begin
                    m_score++;
                    if (M_SPEEDUP && m_score % 8 == 0 && m_speed < 6) m_speed++;
                end
            end
        end
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 16'hFFFF;
    endtask

    task automatic check_model();
        state_t exp_state;
        case (m_state)
            M_RUN:   exp_state = ST_RUN;
            M_HALT:  exp_state = ST_HALT;
            default: exp_state = ST_IDLE;
        endcase
        for (int i = 0; i < NP; i++) begin
            check($sformatf("pipe_x%0d", i), 32'(px(i)), 32'(m_x[i]));
            check($sformatf("pipe_y%0d", i), 32'(py(i)), 32'(m_y[i]));
        end
        check("pass_column", 32'(pass_column), 32'(m_pass));
        check("score", 32'(score), 32'(m_score));
        check("cur_speed", 32'(cur_speed), 32'(m_speed));
        check("running", 32'(running), 32'(m_state == M_RUN));
        check("dbg_state", 32'(dbg_state), 32'(exp_state));
    endtask

    task automatic tick(input bit s, input bit f);
        start    = s;
        finished = f;
        @(posedge gameClk);
        model_edge(s, f);
        #1;
        check_model();
        start = 1'b0;
    endtask

    task automatic check_home(input string tag);
        check({tag, "_x0"}, 32'(px(0)), 32'd640);
        check({tag, "_x1"}, 32'(px(1)), 32'd980);
        check({tag, "_y0"}, 32'(py(0)), 32'd208);
        check({tag, "_y1"}, 32'(py(1)), 32'd208);
        check({tag, "_score"}, 32'(score), 32'd0);
        check({tag, "_speed"}, 32'(cur_speed), 32'd2);
    endtask

    initial begin
        int n;
        bit seen8;
        reset    = 1'b1;
        start    = 1'b0;
        finished = 1'b0;
        model_reset();
        repeat (3) @(posedge gameClk);
        #1;
        check_model();
        check_home("reset");
        check("reset_running", 32'(running), 32'd0);
        check("reset_pass", 32'(pass_column), 32'd0);
        reset = 1'b0;

        // Idle: finished is irrelevant, nothing may move.
        for (int k = 0; k < 1000; k++) tick(1'b0, 1'($urandom_range(0, 1)));
        check_home("idle1000");
        check("idle1000_running", 32'(running), 32'd0);

        tick(1'b1, 1'b0);
        check_home("start");
        check("start_running", 32'(running), 32'd1);

        for (int k = 1; k <= 270; k++) begin
            tick(1'b0, 1'b0);
            if (k == 269) check("tick269_pass", 32'(pass_column), 32'd0);
        end
        check("tick270_pass", 32'(pass_column), 32'd1);
        check("tick270_x0", 32'(px(0)), 32'd100);
        check("tick270_score", 32'(score), 32'd1);

        repeat (49) tick(1'b0, 1'b0);
        check("tick319_x0", 32'(px(0)), 32'd2);
        tick(1'b0, 1'b0);
        check("wrap_x0", 32'(px(0)), 32'd680);
        check("wrap_x1", 32'(px(1)), 32'd340);
        check("wrap_y0_range", 32'(py(0) >= 80 && py(0) <= 335), 32'd1);

        // Freeze with finished, start held off, then restart.
        repeat (20) tick(1'b0, 1'b0);
        for (int k = 0; k < 50; k++) tick(1'b0, 1'b1);
        check("halt_running", 32'(running), 32'd0);
        check("halt_pass", 32'(pass_column), 32'd0);
        tick(1'b1, 1'b0);
        check_home("restart");
        check("restart_running", 32'(running), 32'd1);

        // Random start/finished traffic.
        for (int k = 0; k < 400; k++) begin
            tick(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 29) == 0));
        end

        // Long run from a fresh start to observe score and speed progression.
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        n = 0;
        seen8 = 1'b0;
        while (m_score < 41 && n < 12000) begin
            tick(1'b0, 1'b0);
            n++;
            if (m_score == 8 && !seen8) begin
                seen8 = 1'b1;
                check("score8_speed", 32'(cur_speed), M_SPEEDUP ? 32'd3 : 32'd2);
            end
        end
        check("long_run_in_budget", 32'(n < 12000), 32'd1);
        check("score41_speed", 32'(cur_speed), M_SPEEDUP ? 32'd6 : 32'd2);
        repeat (200) tick(1'b0, 1'b0);
        check("late_speed", 32'(cur_speed), M_SPEEDUP ? 32'd6 : 32'd2);

        // Asynchronous reset between edges while running.
        @(negedge gameClk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_home("async_reset");
        check("async_reset_running", 32'(running), 32'd0);
        check("async_reset_pass", 32'(pass_column), 32'd0);
        check("async_reset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge gameClk);
        reset = 1'b0;

        tick(1'b1, 1'b0);
        for (int k = 1; k <= 270; k++) tick(1'b0, 1'b0);
        check("after_reset_pass", 32'(pass_column), 32'd1);
        check("after_reset_score", 32'(score), 32'd1);
        repeat (60) tick(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_field.md
PIPE_FIELD -- requirements
Module: pipe_field

Interface
REQ-001 Parameter N_PIPES, default 2: number of pipe channels (1..8).
REQ-002 Parameter X_W, default 11: coordinate width, all x/y ports.
REQ-003 Parameters SCREEN_W=640, PIPE_SPACING=340, PIPE_W=60, BIRD_X=160: pixel geometry.
REQ-004 Parameters Y_MIN=80, Y_RANGE_LOG2=8: gap top spans Y_MIN..Y_MIN+2^Y_RANGE_LOG2-1.
REQ-005 Parameters SPEED=2, MAX_SPEED=6, SPEEDUP_PASSES=8, SEED=16'hACE1 (nonzero): motion and randomness.
REQ-006 gameClk  input  1  game tick clock; one clock, all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  single-cycle start/restart request.
REQ-009 finished  input  1  level; freezes the field (game over).
REQ-010 pipe_x  output  N_PIPES*X_W  packed left-edge x per pipe, pipe i at bits [i*X_W +: X_W].
REQ-011 pipe_y  output  N_PIPES*X_W  packed gap-top y per pipe, same packing.
REQ-012 pass_column  output  1  one-cycle pulse when any pipe's right edge passes BIRD_X.
REQ-013 score  output  8  passes counted since last start, saturating.
REQ-014 cur_speed  output  4  current pixels-per-tick.
REQ-015 running  output  1  high while in RUN.

Function
REQ-016 FSM states IDLE, RUN, HALT; IDLE->RUN on start; RUN->HALT on finished; HALT->RUN on start; finished has priority over start in RUN.
REQ-017 Entering RUN from IDLE or HALT reinitialises: pipe_x[i]=SCREEN_W+i*PIPE_SPACING, pipe_y[i]=Y_MIN+2^(Y_RANGE_LOG2-1), score=0, cur_speed=SPEED; pipes do not move in the transition cycle.
REQ-018 In RUN, each tick every pipe: if x>cur_speed, x<=x-cur_speed; else x<=x-cur_speed+N_PIPES*PIPE_SPACING (wrap) and y<=Y_MIN+lfsr[Y_RANGE_LOG2-1:0].
REQ-019 Wrapped pipes in the same tick each take a distinct LFSR slice, pipe i using lfsr rotated left by 3*i.
REQ-020 Pass detect: old x+PIPE_W>BIRD_X and new x+PIPE_W<=BIRD_X, evaluated in X_W+1 bits; pass_column registered, asserted in the update cycle.
REQ-021 Multiple passes in one tick produce one pulse and one score increment; score saturates at 255.
REQ-022 In IDLE and HALT positions, score, cur_speed hold; pass_column=0.
REQ-023 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every gameClk cycle in all states.
REQ-024 Outputs are registered; zero combinational paths from inputs to outputs.

Reset
REQ-025 On reset: state IDLE, running=0, pass_column=0, score=0, cur_speed=SPEED, lfsr=SEED, pipe_x/pipe_y per REQ-017 values.
REQ-026 Reset mid-RUN takes effect immediately; first start afterwards behaves as from power-up.

Configuration
REQ-027 Macro PIPE_FIELD_SPEEDUP_EN defined: cur_speed increments by 1 on each pass that makes score a nonzero multiple of SPEEDUP_PASSES, capped at MAX_SPEED, new speed used from next tick.
REQ-028 Macro undefined: cur_speed constant SPEED; MAX_SPEED, SPEEDUP_PASSES unused.

Structure
REQ-029 Package pipe_pkg holds FSM state typedef, LFSR taps constant, default geometry constants shared with vga and bird blocks.
REQ-030 Sub-module lfsr16 (clock, reset, seed parameter, 16-bit state out) instantiated once.

Verification
REQ-031 Reset, no start, 1000 ticks -> pipe_x={980,640}, pipe_y={208,208}, running=0, score=0.
REQ-032 start, run 270 ticks -> pass_column high exactly on tick 270 (pipe0 x 102->100), score=1.
REQ-033 Run to pipe0 x=2, one more tick -> pipe0 x=680, pipe0 y in 80..335, pipe1 x=340.
REQ-034 finished asserted mid-RUN for 50 ticks -> all outputs frozen, running=0; then start -> reinit values of REQ-031, running=1.
REQ-035 PIPE_FIELD_SPEEDUP_EN defined, run to score 8 -> cur_speed=3 next tick; run to score 40 -> cur_speed=6 and stays 6; undefined -> cur_speed=2 throughout.
REQ-036 reset asserted asynchronously between gameClk edges mid-RUN -> outputs at reset values before next edge.
